// File: rtl/sram_wide_ctrl_if.sv
// CPU-side request/response bundle for sram_wide_ctrl.
//   wr_en / rd_en : store / load request, held until ready=1
//   addr          : CPU byte address, DATA_W/8-aligned
//   wdata         : store data
//   rdata         : load data, valid in the ready=1 cycle of a read
//   ready         : 0 = stall the pipeline, 1 = idle or request completing
// master = pipeline MEM stage, slave = controller.
interface sram_wide_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/sram_wide_ctrl.sv
// SRAM controller between the pipeline MEM stage and an asynchronous SRAM.
// One DATA_W-bit load/store becomes LANES = DATA_W/SRAM_W sequential SRAM_W-bit
// accesses, lane 0 (least significant slice) first, each held WAIT_CYCLES+1 cycles.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus        : CPU request/response bundle (slave side)
//   SRAM_DQ    : bidirectional SRAM data, driven only during write accesses
//   SRAM_ADDR  : SRAM word address (wraps modulo 2^SRAM_AW)
//   SRAM_WE_N  : write enable, active low
//   SRAM_OE_N  : output enable, active low
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N : permanently enabled (0)
module sram_wide_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SRAM_W      = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_wide_ctrl_if.slave    bus,
    inout  wire  [SRAM_W-1:0]  SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);
    localparam int unsigned LANES      = DATA_W / SRAM_W;
    localparam int unsigned LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned BYTE_SHIFT = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                         state_q, state_d;
    logic                           op_write_q, op_write_d;
    logic [LANES-1:0][SRAM_W-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0][SRAM_W-1:0]   rbuf_q, rbuf_d;
    logic [DATA_W-1:0]              rdata_q, rdata_d;
    logic [SRAM_AW-1:0]             sram_addr_q, sram_addr_d;
    logic [LANE_W-1:0]              lane_q, lane_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic [ADDR_W-1:0]              offset;
    logic [ADDR_W-1:0]              word;
    logic [SRAM_AW-1:0]             sram_base;
    logic                           cnt_last;
    logic                           lane_last;
    logic                           req;
    logic                           dq_oe;
    logic [SRAM_W-1:0]              dq_out;

    assign req       = bus.wr_en | bus.rd_en;
    assign cnt_last  = (cnt_q == CNT_W'(WAIT_CYCLES));
    assign lane_last = (lane_q == LANE_W'(LANES - 1));

    // First SRAM word of the request; truncation gives the modulo-2^SRAM_AW wrap.
    always_comb begin
        offset    = bus.addr - ADDR_W'(BASE_ADDR);
        word      = offset >> BYTE_SHIFT;
        sram_base = SRAM_AW'(word * ADDR_W'(LANES));
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_write_q  <= 1'b0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            lane_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = ACCESS;
            ACCESS:  if (cnt_last && lane_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the request, step the lane/hold counters, gather read lanes.
    always_comb begin
        op_write_d  = op_write_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    // wr_en wins when both are asserted
                    op_write_d  = bus.wr_en;
                    wdata_d     = bus.wdata;
                    sram_addr_d = sram_base;
                    lane_d      = '0;
                    cnt_d       = '0;
                end
            end
            ACCESS: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!op_write_q) begin
                        rbuf_d[lane_q] = SRAM_DQ;
                    end
                    if (lane_last) begin
                        // Gathered lanes land in rdata together, so rdata only
                        // changes when a whole read completes.
                        if (!op_write_q) begin
                            rdata_d = rbuf_d;
                        end
                    end else begin
                        lane_d      = lane_q + 1'b1;
                        sram_addr_d = sram_addr_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        bus.ready = 1'b0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = wdata_q[lane_q];
        case (state_q)
            IDLE:   bus.ready = ~req;
            ACCESS: begin
                if (op_write_q) begin
                    dq_oe = 1'b1;
                    // WE_N rises on the last hold cycle so data stays valid past
                    // the rising edge; a single-cycle access keeps it low.
                    SRAM_WE_N = (WAIT_CYCLES == 0) ? 1'b0 : cnt_last;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            DONE:   bus.ready = 1'b1;
            default: ;
        endcase
    end

    assign bus.rdata = rdata_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_DQ   = dq_oe ? dq_out : 'z;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_wide_ctrl.sv
// Bench for sram_wide_ctrl: a default 32/16-bit, 2-wait instance and a
// 64/16-bit, 0-wait instance, each with its own SRAM model. Expected results
// are queued when requests are issued; per-instance monitors pop and compare
// when ready reports completion.
module tb_sram_wide_ctrl;
    localparam int unsigned AW    = 18;
    localparam int unsigned MEMSZ = 1 << AW;
    localparam logic [31:0] BASE  = 32'd1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_wide_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if0 ();
    sram_wide_ctrl_if #(.DATA_W(64), .ADDR_W(32)) if1 ();

    wire  [15:0]   dq0, dq1;
    logic [AW-1:0] sa0, sa1;
    logic          we0, oe0, ce0, ub0, lb0;
    logic          we1, oe1, ce1, ub1, lb1;
    logic [15:0]   mem0 [MEMSZ];
    logic [15:0]   mem1 [MEMSZ];

    sram_wide_ctrl #(
        .DATA_W(32), .SRAM_W(16), .ADDR_W(32), .SRAM_AW(18),
        .BASE_ADDR(1024), .WAIT_CYCLES(2)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0),
        .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_wide_ctrl #(
        .DATA_W(64), .SRAM_W(16), .ADDR_W(32), .SRAM_AW(18),
        .BASE_ADDR(1024), .WAIT_CYCLES(0)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1),
        .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    // Asynchronous SRAM models: drive on OE with WE inactive, capture while WE low.
    assign dq0 = (!oe0 && we0) ? mem0[sa0] : 'z;
    assign dq1 = (!oe1 && we1) ? mem1[sa1] : 'z;
    always @(posedge clk) if (!we0) mem0[sa0] <= dq0;
    always @(posedge clk) if (!we1) mem1[sa1] <= dq1;

    typedef struct {
        bit          is_rd;
        logic [63:0] data;
        int unsigned lat;
        int unsigned sbase;
        int unsigned lanes;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [15:0] ref0 [int unsigned];
    logic [15:0] ref1 [int unsigned];

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference address map: byte offset from BASE, whole CPU words, LANES
    // SRAM words per CPU word, modulo the SRAM size.
    function automatic int unsigned sram_of(input int sel, input logic [31:0] a, input int unsigned lane);
        logic [31:0]     off;
        longint unsigned w;
        int unsigned     bytes, lanes;
        bytes = (sel != 0) ? 8 : 4;
        lanes = (sel != 0) ? 4 : 2;
        off   = a - BASE;
        w     = longint'(off) / bytes;
        return int'((w * lanes + lane) % MEMSZ);
    endfunction

    function automatic logic [15:0] ref_get(input int sel, input int unsigned a);
        if (sel != 0) return ref1.exists(a) ? ref1[a] : 16'h0;
        return ref0.exists(a) ? ref0[a] : 16'h0;
    endfunction

    task automatic ref_put(input int sel, input int unsigned a, input logic [15:0] v);
        if (sel != 0) ref1[a] = v;
        else          ref0[a] = v;
    endtask

    function automatic logic [15:0] sram_rd(input int sel, input int unsigned a);
        return (sel != 0) ? mem1[a % MEMSZ] : mem0[a % MEMSZ];
    endfunction

    // Monitor: counts cycles from acceptance, checks the completion cycle.
    int unsigned trk [2];
    int unsigned cyc [2];
    bit          we_low [2];

    task automatic mon_step(input int sel, input bit rq, input bit rdy, input bit wen,
                            input bit oen, input logic [63:0] rd);
        exp_t        e;
        logic [63:0] got;
        if (!rq) begin
            trk[sel] = 0;
            return;
        end
        if (trk[sel] == 0) begin
            trk[sel]    = 1;
            cyc[sel]    = 0;
            we_low[sel] = 1'b0;
        end else begin
            cyc[sel]++;
        end
        if (!wen) we_low[sel] = 1'b1;
        if (rdy) begin
            trk[sel] = 0;
            if ((sel != 0 ? q1.size() : q0.size()) == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done dut%0d: got completion expected none", sel);
                return;
            end
            e = (sel != 0) ? q1.pop_front() : q0.pop_front();
            chk($sformatf("latency_dut%0d", sel), 64'(cyc[sel]), 64'(e.lat));
            chk($sformatf("done_strobes_dut%0d", sel), {62'b0, wen, oen}, 64'h3);
            if (e.is_rd) begin
                chk($sformatf("rdata_dut%0d", sel), rd, e.data);
                chk($sformatf("read_we_n_dut%0d", sel), {63'b0, we_low[sel]}, 64'h0);
            end else begin
                got = '0;
                for (int unsigned l = 0; l < e.lanes; l++)
                    got[l*16 +: 16] = sram_rd(sel, e.sbase + l);
                chk($sformatf("sram_word_dut%0d", sel), got, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) trk[0] = 0;
        else mon_step(0, if0.wr_en | if0.rd_en, if0.ready, we0, oe0, {32'b0, if0.rdata});
    end

    always @(negedge clk) begin
        if (rst) trk[1] = 0;
        else mon_step(1, if1.wr_en | if1.rd_en, if1.ready, we1, oe1, if1.rdata);
    end

    // Issue one request (entered at posedge+1), queue its expectation, hold it
    // until ready, drop it at the next posedge+1.
    task automatic do_req(input int sel, input bit wr, input bit rd,
                          input logic [31:0] a, input logic [63:0] d);
        exp_t        e;
        logic [63:0] dm;
        int unsigned n;
        bit          rdy;
        dm      = (sel != 0) ? d : {32'b0, d[31:0]};
        e.lanes = (sel != 0) ? 4 : 2;
        e.lat   = e.lanes * ((sel != 0) ? 1 : 3) + 1;
        e.sbase = sram_of(sel, a, 0);
        e.is_rd = !wr;
        e.data  = '0;
        for (int unsigned l = 0; l < e.lanes; l++) begin
            if (wr) ref_put(sel, sram_of(sel, a, l), dm[l*16 +: 16]);
            else    e.data[l*16 +: 16] = ref_get(sel, sram_of(sel, a, l));
        end
        if (wr) e.data = dm;
        if (sel != 0) q1.push_back(e);
        else          q0.push_back(e);

        if (sel != 0) begin
            if1.wr_en = wr; if1.rd_en = rd; if1.addr = a; if1.wdata = d;
        end else begin
            if0.wr_en = wr; if0.rd_en = rd; if0.addr = a; if0.wdata = d[31:0];
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            rdy = (sel != 0) ? if1.ready : if0.ready;
        end while (!rdy && n < 40);
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout dut%0d: got no ready after %0d cycles expected ready", sel, n);
            if (sel != 0) void'(q1.pop_front());
            else          void'(q0.pop_front());
        end
        @(posedge clk);
        #1;
        if (sel != 0) begin if1.wr_en = 1'b0; if1.rd_en = 1'b0; end
        else          begin if0.wr_en = 1'b0; if0.rd_en = 1'b0; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [63:0] d;
        logic [15:0] old1;
        int          sel;
        int unsigned bytes;

        for (int unsigned i = 0; i < MEMSZ; i++) begin
            mem0[i] = 16'h0;
            mem1[i] = 16'h0;
        end
        trk[0] = 0; trk[1] = 0;
        if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.addr = '0; if0.wdata = '0;
        if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.addr = '0; if1.wdata = '0;
        rst = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  {63'b0, if0.ready}, 64'h1);
        chk("rst_we_n",   {63'b0, we0}, 64'h1);
        chk("rst_oe_n",   {63'b0, oe0}, 64'h1);
        chk("rst_addr",   64'(sa0), 64'h0);
        chk("rst_rdata",  64'(if0.rdata), 64'h0);
        chk("tied_pins",  {61'b0, ce0, ub0, lb0}, 64'h0);
        chk("rst_addr1",  64'(sa1), 64'h0);
        chk("rst_ready1", {63'b0, if1.ready}, 64'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed: store/load, back-to-back, both-enables priority, wrap
        do_req(0, 1, 0, 32'd1024, 64'hDEADBEEF);
        chk("sram0_lane0", 64'(mem0[0]), 64'hBEEF);
        chk("sram0_lane1", 64'(mem0[1]), 64'hDEAD);
        do_req(0, 0, 1, 32'd1024, 64'h0);
        do_req(0, 1, 1, 32'd1028, 64'h12345678);
        chk("sram0_word2", {32'b0, mem0[3], mem0[2]}, 64'h12345678);
        do_req(0, 0, 1, 32'd1028, 64'h0);
        do_req(0, 1, 0, BASE + 32'd4 * 32'h1FFFF, 64'hA5A55A5A);
        do_req(0, 1, 0, BASE + 32'd4 * 32'h20000, 64'hC3C33C3C);
        chk("wrap_top", {32'b0, mem0[MEMSZ-1], mem0[MEMSZ-2]}, 64'hA5A55A5A);
        do_req(0, 0, 1, BASE + 32'd4 * 32'h1FFFF, 64'h0);
        do_req(0, 0, 1, BASE + 32'd4 * 32'h20000, 64'h0);
        do_req(0, 0, 1, 32'd1024, 64'h0);

        do_req(1, 1, 0, 32'd1024, 64'h0123456789ABCDEF);
        do_req(1, 0, 1, 32'd1024, 64'h0);
        do_req(1, 1, 0, BASE + 32'd8 * 32'hFFFF, 64'hFEDCBA9876543210);
        do_req(1, 0, 1, BASE + 32'd8 * 32'hFFFF, 64'h0);

        // Randomised traffic
        for (int k = 0; k < 160; k++) begin
            sel   = int'($urandom_range(0, 1));
            bytes = (sel != 0) ? 8 : 4;
            if ($urandom_range(0, 3) == 0) a = $urandom() & ~(bytes - 1);
            else a = BASE + bytes * $urandom_range(0, 15);
            d = {$urandom(), $urandom()};
            case ($urandom_range(0, 4))
                0, 1:    do_req(sel, 1, 0, a, d);
                2:       do_req(sel, 1, 1, a, d);
                default: do_req(sel, 0, 1, a, d);
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset in the third access cycle of a store: lane 0 done, lane 1 not
        old1 = ref_get(0, sram_of(0, 32'd1024, 1));
        if0.wr_en = 1'b1; if0.addr = 32'd1024; if0.wdata = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        if0.wr_en = 1'b0;
        @(negedge clk);
        chk("abort_we_n",  {63'b0, we0}, 64'h1);
        chk("abort_oe_n",  {63'b0, oe0}, 64'h1);
        chk("abort_ready", {63'b0, if0.ready}, 64'h1);
        chk("abort_rdata", 64'(if0.rdata), 64'h0);
        chk("abort_lane0", 64'(mem0[0]), 64'hF00D);
        chk("abort_lane1", 64'(mem0[1]), 64'(old1));
        ref_put(0, sram_of(0, 32'd1024, 0), 16'hF00D);
        @(posedge clk);
        #1;
        do_req(0, 0, 1, 32'd1024, 64'h0);
        do_req(1, 0, 1, 32'd1024, 64'h0);

        repeat (5) @(posedge clk);
        chk("q0_drained", 64'(q0.size()), 64'h0);
        chk("q1_drained", 64'(q1.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
